// File: rtl/prog_clk_div.sv
// -----------------------------------------------------------------------------
// prog_clk_div -- programmable clock divider with tick and runtime reload
//
// Divides Clock by (tc_active+1). In toggle mode clk_out is a square wave of
// period 2*(tc_active+1) cycles. In pulse mode clk_out is high for the single
// cycle after each divider event. A new terminal count can be requested at any
// time. It is held in a shadow register and applied at the next event, or on
// the following cycle if the divider is frozen.
//
// Optional feature macro: PROG_CLK_DIV_TICK_COUNT_EN
//   When defined, the tick_cnt port and a wrapping event counter are built in.
//
// Parameters
//   CNT_W      width of divide counter / terminal count
//   DEFAULT_TC terminal count loaded at reset
//   TCNT_W     width of event counter (only used with the macro)
//
// Ports
//   Clock    in   single clock, rising edge
//   reset    in   asynchronous, active-high reset
//   en       in   count enable (0 freezes the divider)
//   mode     in   0 toggle output, 1 pulse output
//   tc_in    in   requested new terminal count
//   load_req in   request to load tc_in
//   load_ack out  one-cycle pulse when the new terminal count takes effect
//   clk_out  out  divided output (registered)
//   tick     out  one-cycle pulse per divider event (registered)
//   count    out  current divide count
//   tick_cnt out  event count (macro only)
// -----------------------------------------------------------------------------
module prog_clk_div #(
  parameter int          CNT_W      = 32,
  parameter int unsigned DEFAULT_TC = 32'd25000000,
  parameter int          TCNT_W     = 16
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic [CNT_W-1:0] tc_in,
  input  logic             load_req,
  output logic             load_ack,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] count
`ifdef PROG_CLK_DIV_TICK_COUNT_EN
  ,
  output logic [TCNT_W-1:0] tick_cnt
`endif
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [CNT_W-1:0] tc_active_r;
  logic [CNT_W-1:0] tc_nxt_s;
  logic [CNT_W-1:0] shadow_r;
  logic [CNT_W-1:0] shadow_nxt_s;
  logic             clk_r;
  logic             clk_nxt_s;
  logic             tick_r;
  logic             ack_r;
  logic             ack_nxt_s;
  logic             pending_r;
  logic             pending_nxt_s;
  logic             mode_r;
  logic             mode_nxt_s;
  logic             event_s;
  logic             apply_s;

  // An event is an enabled cycle at terminal count. A pending load is applied
  // at an event, or immediately while frozen.
  assign event_s = en & (count_r == tc_active_r);
  assign apply_s = pending_r & (~en | event_s);

  // Next-state computation for divider, output shaping and reload handshake.
  always_comb begin
    count_nxt_s   = count_r;
    tc_nxt_s      = tc_active_r;
    shadow_nxt_s  = shadow_r;
    clk_nxt_s     = clk_r;
    ack_nxt_s     = 1'b0;
    pending_nxt_s = pending_r;
    mode_nxt_s    = mode_r;

    // Reload handshake. pending_r is still set in the apply cycle, so a
    // simultaneous load_req is ignored rather than captured.
    if (apply_s) begin
      tc_nxt_s      = shadow_r;
      ack_nxt_s     = 1'b1;
      pending_nxt_s = 1'b0;
    end else if (load_req & ~pending_r) begin
      shadow_nxt_s  = tc_in;
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end

    if (~en) begin
      // Frozen: mode may be resampled. clk_out holds, and count clears only on reload.
      mode_nxt_s = mode;
      if (pending_r) begin
        count_nxt_s = {CNT_W{1'b0}};
      end else begin
        count_nxt_s = count_r;
      end
    end else if (event_s) begin
      // The freshly sampled mode shapes the output of this event. This lets
      // a mode change made mid-interval act cleanly at the interval boundary.
      mode_nxt_s  = mode;
      count_nxt_s = {CNT_W{1'b0}};
      if (mode) begin
        clk_nxt_s = 1'b1;
      end else begin
        clk_nxt_s = ~clk_r;
      end
    end else begin
      count_nxt_s = count_r + CNT_W'(1'b1);
      if (mode_r) begin
        clk_nxt_s = 1'b0;
      end else begin
        clk_nxt_s = clk_r;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      count_r     <= {CNT_W{1'b0}};
      tc_active_r <= CNT_W'(DEFAULT_TC);
      shadow_r    <= {CNT_W{1'b0}};
      clk_r       <= 1'b0;
      tick_r      <= 1'b0;
      ack_r       <= 1'b0;
      pending_r   <= 1'b0;
      mode_r      <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      tc_active_r <= tc_nxt_s;
      shadow_r    <= shadow_nxt_s;
      clk_r       <= clk_nxt_s;
      tick_r      <= event_s;
      ack_r       <= ack_nxt_s;
      pending_r   <= pending_nxt_s;
      mode_r      <= mode_nxt_s;
    end
  end

  assign count    = count_r;
  assign clk_out  = clk_r;
  assign tick     = tick_r;
  assign load_ack = ack_r;

`ifdef PROG_CLK_DIV_TICK_COUNT_EN
  logic [TCNT_W-1:0] tick_cnt_r;

  // Wrapping count of divider events.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      tick_cnt_r <= {TCNT_W{1'b0}};
    end else if (event_s) begin
      tick_cnt_r <= tick_cnt_r + TCNT_W'(1'b1);
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

  assign tick_cnt = tick_cnt_r;
`endif

endmodule

// File: tb/tb_prog_clk_div.sv
// -----------------------------------------------------------------------------
// tb_prog_clk_div -- self-checking bench for prog_clk_div
// Directed scenarios use hand-derived cycle expectations. A randomized run is
// compared against a cycle reference model built from the behavioural rules.
// -----------------------------------------------------------------------------
module tb_prog_clk_div;
  localparam int CNT_W  = 8;
  localparam int TCNT_W = 4;
  localparam int DEF_TC = 4;

  logic             Clock = 1'b0;
  logic             reset;
  logic             en;
  logic             mode;
  logic [CNT_W-1:0] tc_in;
  logic             load_req;
  logic             load_ack;
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] count;
`ifdef PROG_CLK_DIV_TICK_COUNT_EN
  logic [TCNT_W-1:0] tick_cnt;
`endif

  int checks = 0;
  int errors = 0;

  prog_clk_div #(.CNT_W(CNT_W), .DEFAULT_TC(DEF_TC), .TCNT_W(TCNT_W)) dut (
    .Clock(Clock), .reset(reset), .en(en), .mode(mode), .tc_in(tc_in),
    .load_req(load_req), .load_ack(load_ack), .clk_out(clk_out),
    .tick(tick), .count(count)
`ifdef PROG_CLK_DIV_TICK_COUNT_EN
    , .tick_cnt(tick_cnt)
`endif
  );

  always #5 Clock = ~Clock;

  // ---------------- reference model ----------------
  logic [CNT_W-1:0]  m_count, m_tc, m_shadow;
  logic              m_clk, m_tick, m_ack, m_pend, m_mode;
  logic [TCNT_W-1:0] m_tcnt;
  wire m_ev      = en && (m_count == m_tc);
  wire m_apply   = m_pend && (!en || m_ev);
  wire m_newmode = (m_ev || !en) ? mode : m_mode;

  always @(posedge Clock or posedge reset) begin : ref_model
    if (reset) begin
      m_count <= 8'd0; m_tc <= 8'(DEF_TC); m_shadow <= 8'd0;
      m_clk <= 1'b0; m_tick <= 1'b0; m_ack <= 1'b0; m_pend <= 1'b0;
      m_mode <= 1'b0; m_tcnt <= 4'd0;
    end else begin
      m_tick <= m_ev;
      m_ack  <= m_apply;
      if (m_apply) begin
        m_tc <= m_shadow; m_pend <= 1'b0;
      end else if (load_req && !m_pend) begin
        m_shadow <= tc_in; m_pend <= 1'b1;
      end
      if (m_ev || m_apply) m_count <= 8'd0;
      else if (en)         m_count <= m_count + 8'd1;
      if (m_ev)                m_clk <= m_newmode ? 1'b1 : ~m_clk;
      else if (en && m_mode)   m_clk <= 1'b0;
      m_mode <= m_newmode;
      if (m_ev) m_tcnt <= m_tcnt + 4'd1;
    end
  end

  // ---------------- helpers (no checking) ----------------
  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    en = 1'b0; mode = 1'b0; load_req = 1'b0; tc_in = 8'd0;
    reset = 1'b1;
    repeat (2) next_cycle();
    checks++; if (count !== 8'd0)   begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk_out got %b exp 0", clk_out); end
    checks++; if (tick !== 1'b0)    begin errors++; $display("FAIL reset_tick got %b exp 0", tick); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_load_ack got %b exp 0", load_ack); end
`ifdef PROG_CLK_DIV_TICK_COUNT_EN
    checks++; if (tick_cnt !== 4'd0) begin errors++; $display("FAIL reset_tick_cnt got %0d exp 0", tick_cnt); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_toggle();
    logic [7:0] ec; logic et, eclk;
    en = 1'b1; mode = 1'b0; load_req = 1'b0;
    apply_reset();
    for (int n = 1; n <= 20; n++) begin
      next_cycle();
      ec = 8'(n % 5); et = (n % 5 == 0); eclk = ((n / 5) % 2) == 1;
      checks++; if (count !== ec)     begin errors++; $display("FAIL toggle_count n=%0d got %0d exp %0d", n, count, ec); end
      checks++; if (tick !== et)      begin errors++; $display("FAIL toggle_tick n=%0d got %b exp %b", n, tick, et); end
      checks++; if (clk_out !== eclk) begin errors++; $display("FAIL toggle_clk n=%0d got %b exp %b", n, clk_out, eclk); end
    end
  endtask

  task automatic test_pulse_mode_switch();
    logic et, eclk;
    en = 1'b1; mode = 1'b1; load_req = 1'b0;
    apply_reset();
    for (int n = 1; n <= 25; n++) begin
      next_cycle();
      et   = (n % 5 == 0);
      eclk = (n < 20) ? (n % 5 == 0) : (((n - 20) / 5) % 2 == 0);
      checks++; if (tick !== et)      begin errors++; $display("FAIL pulse_tick n=%0d got %b exp %b", n, tick, et); end
      checks++; if (clk_out !== eclk) begin errors++; $display("FAIL pulse_clk n=%0d got %b exp %b", n, clk_out, eclk); end
      if (n == 17) mode = 1'b0;
    end
  endtask

  task automatic test_load_pending();
    logic [7:0] ec; logic et, ea;
    en = 1'b1; mode = 1'b0; load_req = 1'b0;
    apply_reset();
    for (int n = 1; n <= 14; n++) begin
      next_cycle();
      ec = (n < 5) ? 8'(n) : 8'((n - 5) % 3);
      et = (n >= 5) && ((n - 5) % 3 == 0);
      ea = (n == 5);
      checks++; if (count !== ec)    begin errors++; $display("FAIL load_count n=%0d got %0d exp %0d", n, count, ec); end
      checks++; if (tick !== et)     begin errors++; $display("FAIL load_tick n=%0d got %b exp %b", n, tick, et); end
      checks++; if (load_ack !== ea) begin errors++; $display("FAIL load_ack n=%0d got %b exp %b", n, load_ack, ea); end
      if (n == 1) begin load_req = 1'b1; tc_in = 8'd2; end
      if (n == 2) begin load_req = 1'b1; tc_in = 8'd6; end
      if (n == 3) load_req = 1'b0;
    end
  endtask

  task automatic test_freeze_load();
    logic [7:0] ec; logic et, ea, eclk;
    en = 1'b1; mode = 1'b0; load_req = 1'b0;
    apply_reset();
    for (int n = 1; n <= 30; n++) begin
      next_cycle();
      ea = (n == 20); et = 1'b0;
      if (n <= 8)       begin ec = 8'(n % 5); et = (n == 5); eclk = (n >= 5); end
      else if (n <= 19) begin ec = 8'd3; eclk = 1'b1; end
      else if (n <= 21) begin ec = 8'd0; eclk = 1'b1; end
      else if (n <= 28) begin ec = 8'(n - 21); eclk = 1'b1; end
      else              begin ec = 8'(n - 29); et = (n == 29); eclk = 1'b0; end
      checks++; if (count !== ec)     begin errors++; $display("FAIL freeze_count n=%0d got %0d exp %0d", n, count, ec); end
      checks++; if (tick !== et)      begin errors++; $display("FAIL freeze_tick n=%0d got %b exp %b", n, tick, et); end
      checks++; if (load_ack !== ea)  begin errors++; $display("FAIL freeze_ack n=%0d got %b exp %b", n, load_ack, ea); end
      checks++; if (clk_out !== eclk) begin errors++; $display("FAIL freeze_clk n=%0d got %b exp %b", n, clk_out, eclk); end
      if (n == 8)  en = 1'b0;
      if (n == 18) begin load_req = 1'b1; tc_in = 8'd7; end
      if (n == 19) load_req = 1'b0;
      if (n == 21) en = 1'b1;
    end
  endtask

  task automatic test_tc_zero_and_async_reset();
    logic eclk;
    en = 1'b0; mode = 1'b0; load_req = 1'b1; tc_in = 8'd0;
    apply_reset();
    for (int n = 1; n <= 10; n++) begin
      next_cycle();
      if (n == 1) load_req = 1'b0;
      if (n == 2) begin
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL tc0_ack got %b exp 1", load_ack); end
        en = 1'b1;
      end
      if (n >= 3) begin
        eclk = ((n - 2) % 2) == 1;
        checks++; if (clk_out !== eclk) begin errors++; $display("FAIL tc0_clk n=%0d got %b exp %b", n, clk_out, eclk); end
        checks++; if (tick !== 1'b1)    begin errors++; $display("FAIL tc0_tick n=%0d got %b exp 1", n, tick); end
        checks++; if (count !== 8'd0)   begin errors++; $display("FAIL tc0_count n=%0d got %0d exp 0", n, count); end
      end
    end
    // capture a load, then reset before it can apply
    load_req = 1'b1; tc_in = 8'd1;
    @(posedge Clock);
    #3 reset = 1'b1;
    #1;
    checks++; if (count !== 8'd0)    begin errors++; $display("FAIL areset_count got %0d exp 0", count); end
    checks++; if (clk_out !== 1'b0)  begin errors++; $display("FAIL areset_clk got %b exp 0", clk_out); end
    checks++; if (tick !== 1'b0)     begin errors++; $display("FAIL areset_tick got %b exp 0", tick); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL areset_ack got %b exp 0", load_ack); end
    load_req = 1'b0;
    next_cycle();
    reset = 1'b0; en = 1'b1; mode = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      next_cycle();
      checks++; if (count !== 8'(n % 5))  begin errors++; $display("FAIL postreset_count n=%0d got %0d exp %0d", n, count, n % 5); end
      checks++; if (tick !== (n % 5 == 0)) begin errors++; $display("FAIL postreset_tick n=%0d got %b", n, tick); end
      checks++; if (load_ack !== 1'b0)    begin errors++; $display("FAIL postreset_ack n=%0d got %b exp 0", n, load_ack); end
    end
  endtask

`ifdef PROG_CLK_DIV_TICK_COUNT_EN
  task automatic test_tick_cnt();
    logic [3:0] ecnt;
    en = 1'b1; mode = 1'b0; load_req = 1'b0;
    apply_reset();
    for (int n = 1; n <= 85; n++) begin
      next_cycle();
      ecnt = 4'((n / 5) % 16);
      checks++; if (tick_cnt !== ecnt) begin errors++; $display("FAIL tick_cnt n=%0d got %0d exp %0d", n, tick_cnt, ecnt); end
    end
  endtask
`endif

  task automatic test_random();
    en = 1'b1; mode = 1'b0; load_req = 1'b0; tc_in = 8'd0;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      en       = ($urandom_range(0, 9) != 0);
      mode     = ($urandom_range(0, 15) == 0) ? ~mode : mode;
      load_req = ($urandom_range(0, 9) == 0);
      tc_in    = 8'($urandom_range(0, 7));
      next_cycle();
      checks++; if (count !== m_count)  begin errors++; $display("FAIL rand_count n=%0d got %0d exp %0d", n, count, m_count); end
      checks++; if (clk_out !== m_clk)  begin errors++; $display("FAIL rand_clk n=%0d got %b exp %b", n, clk_out, m_clk); end
      checks++; if (tick !== m_tick)    begin errors++; $display("FAIL rand_tick n=%0d got %b exp %b", n, tick, m_tick); end
      checks++; if (load_ack !== m_ack) begin errors++; $display("FAIL rand_ack n=%0d got %b exp %b", n, load_ack, m_ack); end
`ifdef PROG_CLK_DIV_TICK_COUNT_EN
      checks++; if (tick_cnt !== m_tcnt) begin errors++; $display("FAIL rand_tick_cnt n=%0d got %0d exp %0d", n, tick_cnt, m_tcnt); end
`endif
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; mode = 1'b0; load_req = 1'b0; tc_in = 8'd0;
    #2;
    test_reset();
    test_toggle();
    test_pulse_mode_switch();
    test_load_pending();
    test_freeze_load();
    test_tc_zero_and_async_reset();
`ifdef PROG_CLK_DIV_TICK_COUNT_EN
    test_tick_cnt();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 SHALL provide parameter CNT_W, default 32, width of the divide counter and terminal-count value.
REQ-002 SHALL provide parameter DEFAULT_TC, default 25000000, terminal count loaded at reset (must fit in CNT_W).
REQ-003 SHALL provide parameter TCNT_W, default 16, width of the event counter.
REQ-004 SHALL provide port: Clock  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL provide port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port: en  input  1  count enable; 0 freezes the divider.
REQ-007 SHALL provide port: mode  input  1  output mode: 0 toggle (square wave), 1 pulse.
REQ-008 SHALL provide port: tc_in  input  CNT_W  requested new terminal count.
REQ-009 SHALL provide port: load_req  input  1  request to load tc_in.
REQ-010 SHALL provide port: load_ack  output  1  one-cycle pulse when the new terminal count takes effect.
REQ-011 SHALL provide port: clk_out  output  1  divided output, registered.
REQ-012 SHALL provide port: tick  output  1  one-cycle pulse on every divider event, registered.
REQ-013 SHALL provide port: count  output  CNT_W  current divide count.
REQ-014 SHALL provide port: tick_cnt  output  TCNT_W  event count (present only per REQ-030).

Function
REQ-015 SHALL, when en=1 and count!=tc_active, increment count by 1 and drive tick=0.
REQ-016 SHALL, when en=1 and count==tc_active (an event), set count to 0 and drive tick=1 for exactly that following cycle; interval between events is tc_active+1 cycles.
REQ-017 SHALL sample mode into mode_q only at an event or while en=0; mode changes while enabled take effect at the next event.
REQ-018 SHALL, in toggle mode (mode_q=0), invert clk_out at each event; clk_out period = 2*(tc_active+1) cycles.
REQ-019 SHALL, in pulse mode (mode_q=1), drive clk_out=1 for the one cycle following an event and 0 otherwise.
REQ-020 SHALL, when en=0, hold count and clk_out unchanged and drive tick=0.
REQ-021 SHALL, when load_req=1 and no load is pending, capture tc_in into a shadow register and set pending; load_req while pending is ignored.
REQ-022 SHALL, with pending set and en=1, apply the shadow to tc_active at the next event (count<=0), pulse load_ack for one cycle, and clear pending; an event coinciding with capture does not apply it.
REQ-023 SHALL, with pending set and en=0, apply the shadow on the next cycle, clear count to 0, hold clk_out, pulse load_ack, clear pending.
REQ-024 SHALL accept tc_active=0: an event every enabled cycle; toggle-mode clk_out = Clock/2.
REQ-025 SHALL use unsigned CNT_W arithmetic; count never exceeds tc_active and never wraps past it.

Reset
REQ-026 SHALL, while reset=1, asynchronously force count=0, clk_out=0, tick=0, load_ack=0, pending=0, mode_q=0, tc_active=DEFAULT_TC, tick_cnt=0.
REQ-027 SHALL, on reset assertion mid-operation, discard any pending load without load_ack.
REQ-028 SHALL begin counting on the first rising Clock edge after reset deasserts with en=1 (count=1 after that edge).

Configuration
REQ-029 SHALL use macro PROG_CLK_DIV_TICK_COUNT_EN to compile the event counter in or out.
REQ-030 SHALL, with the macro defined, provide tick_cnt incrementing by 1 at every event, wrapping from 2^TCNT_W-1 to 0; without it, tick_cnt port and logic are absent and all other behaviour is unchanged.

Verification
REQ-031 SHALL cover: reset, DEFAULT_TC=4, en=1, mode=0 -> clk_out toggles every 5 cycles (period 10), tick pulses every 5 cycles.
REQ-032 SHALL cover: tc=4, mode=1 -> clk_out and tick high 1 cycle in every 5; mode switched to 0 mid-interval -> first toggle (clk_out 0->1) at next event.
REQ-033 SHALL cover: load_req with tc_in=2 at count=1 (tc=4) -> load_ack at event after count 4, subsequent events every 3 cycles; second load_req while pending ignored.
REQ-034 SHALL cover: en=0 at count=3 for 10 cycles -> count stays 3, tick=0; load_req tc_in=7 during freeze -> next cycle count=0, load_ack=1, clk_out held.
REQ-035 SHALL cover: tc_in=0 loaded, mode=0 -> clk_out = Clock/2; reset asserted mid-cycle -> all outputs 0 immediately, tc_active=DEFAULT_TC.
REQ-036 SHALL cover (macro defined, TCNT_W=4): 17 events -> tick_cnt reads 15 then 0 then 1.
